// File: rtl/pixel_stream_pkg.sv
// Shared definitions for the pixel stream: default pixel width, the
// streamer FSM states, and the pixel+marker payload that travels from
// the raster source to the 3x3 filter stages.
package pixel_stream_pkg;

    localparam int unsigned PIX_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } stream_state_t;

    // One pixel together with its raster-position markers.
    typedef struct packed {
        logic [PIX_DATA_W-1:0] data;
        logic                  sof;
        logic                  eol;
        logic                  eof;
        logic                  border;
    } pixel_t;

endpackage

// File: rtl/pixel_skid_buf.sv
// One-entry skid buffer for pixel_t with valid/ready on both sides.
// The output stage is a register; the skid entry catches the pixel that
// arrives in the cycle the consumer stalls, so s_ready can itself be a
// register (no combinational path from m_ready back to the producer).
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   s_valid/s_ready      upstream handshake, s_data payload
//   m_valid/m_ready      downstream handshake, m_data payload (registered)
module pixel_skid_buf
    import pixel_stream_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   s_valid,
    output logic   s_ready,
    input  pixel_t s_data,
    output logic   m_valid,
    input  logic   m_ready,
    output pixel_t m_data
);

    pixel_t skid_data;

    // s_ready low means the skid entry holds a pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid   <= 1'b0;
            m_data    <= '0;
            s_ready   <= 1'b1;
            skid_data <= '0;
        end else if (m_ready || !m_valid) begin
            // Output stage free: drain the skid first, else take the input.
            m_valid <= !s_ready || s_valid;
            if (!s_ready) begin
                m_data <= skid_data;
            end else if (s_valid) begin
                m_data <= s_data;
            end
            s_ready <= 1'b1;
        end else if (s_valid && s_ready) begin
            // Output stalled: park the incoming pixel in the skid entry.
            skid_data <= s_data;
            s_ready   <= 1'b0;
        end
    end

endmodule

// File: rtl/pixel_raster_streamer.sv
// Frame-buffered raster source. Holds one ROWS x COLS greyscale frame
// written through a simple write port and, on start, streams it in raster
// order over valid/ready with start-of-frame, end-of-line and end-of-frame
// markers. A read-ahead stage feeding a one-entry skid buffer sustains one
// pixel per cycle while m_ready stays high.
//
// Optional feature macro: PIXEL_STREAM_BORDER_EN adds the m_border output,
// asserted on pixels in the first/last row or first/last column.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   wr_en, wr_addr, wr_data    frame-buffer write (honoured only while idle)
//   start                      begin streaming (honoured only while idle)
//   busy, done                 status; done pulses once after the eof beat
//   m_valid, m_ready, m_data   pixel stream
//   m_sof, m_eol, m_eof        raster markers registered with the pixel
//   m_border                   border marker (PIXEL_STREAM_BORDER_EN only)
module pixel_raster_streamer
    import pixel_stream_pkg::*;
#(
    parameter int unsigned ROWS   = 242,
    parameter int unsigned COLS   = 247,
    parameter int unsigned DATA_W = PIX_DATA_W,
    parameter int unsigned ADDR_W = $clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof
`ifdef PIXEL_STREAM_BORDER_EN
    ,
    output logic              m_border
`endif
);

    localparam int unsigned NPIX  = ROWS * COLS;
    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam int unsigned COL_W = $clog2(COLS);

    localparam logic [ADDR_W:0]   NPIX_EXT  = (ADDR_W + 1)'(NPIX);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NPIX - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);

    stream_state_t state;
    stream_state_t next_state;

    logic start_ok_c;
    logic wr_ok_c;
    logic rd_issue_c;
    logic busy_d;
    logic done_d;
    logic hs_c;
    logic border_c;

    logic [DATA_W-1:0] mem [NPIX];
    logic [DATA_W-1:0] rd_data;

    logic              rd_more;
    logic [ADDR_W-1:0] rd_addr;
    logic [ROW_W-1:0]  rd_row;
    logic [COL_W-1:0]  rd_col;

    logic   pipe_valid;
    logic   pipe_sof;
    logic   pipe_eol;
    logic   pipe_eof;
    logic   pipe_border;
    pixel_t pipe_pix;

    logic   skid_s_ready;
    logic   out_valid;
    pixel_t out_pix;

    assign hs_c = out_valid && m_ready;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = PRIME;
            PRIME:   next_state = STREAM;
            STREAM:  if (hs_c && out_pix.eof) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM output decode: write/start gating, read-ahead issue, status.
    always_comb begin
        start_ok_c = 1'b0;
        wr_ok_c    = 1'b0;
        rd_issue_c = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        if (state == IDLE) begin
            start_ok_c = start;
            wr_ok_c    = wr_en && ({1'b0, wr_addr} < NPIX_EXT);
        end
        // Read only when the pipe stage will be empty or drained this cycle.
        if ((state == PRIME) || (state == STREAM)) begin
            rd_issue_c = rd_more && (!pipe_valid || skid_s_ready);
        end
        busy_d = (next_state != IDLE);
        done_d = (next_state == DONE);
    end

    // Registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_d;
            done <= done_d;
        end
    end

    // Frame buffer: single write port, synchronous read. Not reset.
    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_issue_c) begin
            rd_data <= mem[rd_addr];
        end
    end

`ifdef PIXEL_STREAM_BORDER_EN
    assign border_c = (rd_row == '0) || (rd_row == ROW_LAST) ||
                      (rd_col == '0) || (rd_col == COL_LAST);
`else
    assign border_c = 1'b0;
`endif

    // Read-side raster position; markers are computed at issue time and
    // ride alongside the read data into the pipe stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_more     <= 1'b0;
            rd_addr     <= '0;
            rd_row      <= '0;
            rd_col      <= '0;
            pipe_valid  <= 1'b0;
            pipe_sof    <= 1'b0;
            pipe_eol    <= 1'b0;
            pipe_eof    <= 1'b0;
            pipe_border <= 1'b0;
        end else begin
            if (start_ok_c) begin
                rd_more <= 1'b1;
                rd_addr <= '0;
                rd_row  <= '0;
                rd_col  <= '0;
            end else if (rd_issue_c) begin
                rd_addr <= rd_addr + ADDR_W'(1);
                if (rd_col == COL_LAST) begin
                    rd_col <= '0;
                    rd_row <= rd_row + ROW_W'(1);
                end else begin
                    rd_col <= rd_col + COL_W'(1);
                end
                if (rd_addr == ADDR_LAST) begin
                    rd_more <= 1'b0;
                end
            end

            if (rd_issue_c) begin
                pipe_valid  <= 1'b1;
                pipe_sof    <= (rd_row == '0) && (rd_col == '0);
                pipe_eol    <= (rd_col == COL_LAST);
                pipe_eof    <= (rd_row == ROW_LAST) && (rd_col == COL_LAST);
                pipe_border <= border_c;
            end else if (skid_s_ready) begin
                pipe_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        pipe_pix        = '0;
        pipe_pix.data   = PIX_DATA_W'(rd_data);
        pipe_pix.sof    = pipe_sof;
        pipe_pix.eol    = pipe_eol;
        pipe_pix.eof    = pipe_eof;
        pipe_pix.border = pipe_border;
    end

    pixel_skid_buf u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (pipe_valid),
        .s_ready (skid_s_ready),
        .s_data  (pipe_pix),
        .m_valid (out_valid),
        .m_ready (m_ready),
        .m_data  (out_pix)
    );

    assign m_valid = out_valid;
    assign m_data  = DATA_W'(out_pix.data);
    assign m_sof   = out_pix.sof;
    assign m_eol   = out_pix.eol;
    assign m_eof   = out_pix.eof;

`ifdef PIXEL_STREAM_BORDER_EN
    assign m_border = out_pix.border;
`else
    logic border_unused;
    assign border_unused = out_pix.border;
`endif

endmodule
